// File: rtl/outlier_pkg.sv
// Shared types and widths for the outlier-detection datapath; no logic.
package outlier_pkg;
    localparam int COORD_W_DEF = 16;
    localparam int ROM_WORD_W  = 2 * COORD_W_DEF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2,
        HALT    = 2'd3
    } fetch_state_t;
endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus a third flop; rise_o pulses for one clk on a synchronized rising edge.
// Latency: input high at edge N gives rise_o high in the cycle after edge N+1; no backpressure.
module sync_edge_detect (
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic rise_o
);
    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;
endmodule

// File: rtl/point_fetch.sv
// Sequences one ROM read per new_number edge and presents x/y with a one-cycle point_valid strobe.
// Latency: request edge to strobe is ROM_LAT+3 clks; one request queues while busy, further ones count as drops.
module point_fetch
    import outlier_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int NUM_POINTS = 256,
    parameter int ROM_LAT    = 1,
    parameter int COORD_W    = COORD_W_DEF,
    parameter int WRAP       = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 new_number_i,
    output logic [ADDR_W-1:0]    rom_addr_o,
    input  logic [2*COORD_W-1:0] rom_dout_i,
    output logic [COORD_W-1:0]   x_coord_o,
    output logic [COORD_W-1:0]   y_coord_o,
    output logic                 point_valid_o,
    output logic [ADDR_W-1:0]    point_index_o,
    output logic                 busy_o,
    output logic                 pass_done_o,
    output logic [7:0]           drop_count_o
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_POINTS - 1);
    localparam logic [1:0]        WAIT_LAST = 2'(ROM_LAT - 1);

    fetch_state_t        state_q, state_d;
    logic [1:0]          wait_cnt_q, wait_cnt_d;
    logic                pending_q, pending_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0]   point_index_q, point_index_d;
    logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
    logic                pv_q, pv_d;
    logic                pass_done_q, pass_done_d;
    logic [7:0]          drop_q, drop_d;
    logic                req, at_last, busy, halting;

    sync_edge_detect u_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .async_i (new_number_i),
        .rise_o  (req)
    );

    assign at_last = (rom_addr_q == LAST_ADDR);
    assign busy    = (state_q == WAIT) || (state_q == CAPTURE);
    assign halting = (state_q == CAPTURE) && at_last && (WRAP == 0);

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        pending_d     = pending_q;
        rom_addr_d    = rom_addr_q;
        point_index_d = point_index_q;
        x_d           = x_q;
        y_d           = y_q;
        pv_d          = 1'b0;
        pass_done_d   = pass_done_q;
        drop_d        = drop_q;

        // A request during a fetch queues once; any more are dropped, except on the final halting capture.
        if (req && busy && !halting) begin
            if (!pending_q)
                pending_d = 1'b1;
            else if (drop_q != 8'hFF)
                drop_d = drop_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (req || pending_q) begin
                    state_d    = WAIT;
                    wait_cnt_d = 2'd0;
                    pending_d  = req && pending_q;
                end
            end
            WAIT: begin
                if (wait_cnt_q == WAIT_LAST)
                    state_d = CAPTURE;
                else
                    wait_cnt_d = wait_cnt_q + 2'd1;
            end
            CAPTURE: begin
                x_d           = rom_dout_i[2*COORD_W-1:COORD_W];
                y_d           = rom_dout_i[COORD_W-1:0];
                point_index_d = rom_addr_q;
                pv_d          = 1'b1;
                pass_done_d   = at_last;
                rom_addr_d    = (at_last && WRAP != 0) ? '0 : rom_addr_q + ADDR_W'(1);
                if (halting) begin
                    state_d   = HALT;
                    pending_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            wait_cnt_q    <= 2'd0;
            pending_q     <= 1'b0;
            rom_addr_q    <= '0;
            point_index_q <= '0;
            x_q           <= '0;
            y_q           <= '0;
            pv_q          <= 1'b0;
            pass_done_q   <= 1'b0;
            drop_q        <= 8'd0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            pending_q     <= pending_d;
            rom_addr_q    <= rom_addr_d;
            point_index_q <= point_index_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pv_q          <= pv_d;
            pass_done_q   <= pass_done_d;
            drop_q        <= drop_d;
        end
    end

    assign rom_addr_o    = rom_addr_q;
    assign x_coord_o     = x_q;
    assign y_coord_o     = y_q;
    assign point_valid_o = pv_q;
    assign point_index_o = point_index_q;
    assign busy_o        = busy;
    assign pass_done_o   = pass_done_q;
    assign drop_count_o  = drop_q;
endmodule
